// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings, receiver state enum and oversample divisor helper
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        BD_1200 = 2'b00,
        BD_2400 = 2'b01,
        BD_4800 = 2'b10,
        BD_9600 = 2'b11
    } bd_sel_e;

    typedef enum logic [1:0] {
        PRTY_NONE     = 2'b00,
        PRTY_ODD      = 2'b01,
        PRTY_EVEN     = 2'b10,
        PRTY_NONE_ALT = 2'b11
    } prty_sel_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_e;

    typedef struct packed {
        bd_sel_e   bd;
        prty_sel_e prty;
        logic      stop2;
        logic      dbit8;
    } rx_cfg_t;

    // Clocks per oversample tick: CLK / (16 x baud), baud = 1200 << bd.
    function automatic int unsigned os_divisor(input logic [1:0] bd, input int unsigned clk_hz);
        return clk_hz / (OVERSAMPLE * (32'd1200 << bd));
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame configuration and received-word bundle for uart_rx
interface uart_rx_if;

    logic       data_in_Rx;
    logic [1:0] bd_sel;
    logic [1:0] prty_sel;
    logic       stop_sel;
    logic       data_bit_sel;

    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output data_in_Rx, bd_sel, prty_sel, stop_sel, data_bit_sel,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  data_in_Rx, bd_sel, prty_sel, stop_sel, data_bit_sel,
        output data_out, data_valid, parity_err, frame_err, busy
    );

endinterface

// File: rtl/uart_rx_baud_gen.sv
// rtl/uart_rx_baud_gen.sv - oversample tick generator with selectable divisor and restart
module uart_rx_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 1_843_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart_i,
    input  logic [1:0] bd_sel_i,
    output logic       tick_o
);

    localparam int unsigned MAX_DIV = os_divisor(2'b00, CLK_FREQ_HZ);
    localparam int CNT_W = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [CNT_W-1:0] LAST_1200 = CNT_W'(os_divisor(2'b00, CLK_FREQ_HZ) - 1);
    localparam logic [CNT_W-1:0] LAST_2400 = CNT_W'(os_divisor(2'b01, CLK_FREQ_HZ) - 1);
    localparam logic [CNT_W-1:0] LAST_4800 = CNT_W'(os_divisor(2'b10, CLK_FREQ_HZ) - 1);
    localparam logic [CNT_W-1:0] LAST_9600 = CNT_W'(os_divisor(2'b11, CLK_FREQ_HZ) - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_cnt;

    always_comb begin
        last_cnt = LAST_1200;
        case (bd_sel_i)
            2'b00:   last_cnt = LAST_1200;
            2'b01:   last_cnt = LAST_2400;
            2'b10:   last_cnt = LAST_4800;
            default: last_cnt = LAST_9600;
        endcase
    end

    assign tick_o = (cnt_q == last_cnt);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with parity, framing and break handling
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 1_843_200,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave rx_if
);

    localparam int SMP_W = $clog2(OVERSAMPLE);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);

    logic [1:0]       sync_q;
    logic             rx_prev_q;
    rx_state_e        state_q;
    rx_cfg_t          cfg_q;
    logic [SMP_W-1:0] smp_q;
    logic [2:0]       bit_q;
    logic             stop_q;
    logic [7:0]       sh_q;
    logic             pe_q;
    logic             fe_q;
    logic [7:0]       data_out_q;
    logic             data_valid_q;
    logic             parity_err_q;
    logic             frame_err_q;
    logic             busy_q;

    logic       rx_s;
    logic       tick;
    logic       start_edge;
    logic       restart;
    logic       mid_bit;
    logic       parity_en;
    logic       exp_parity;
    logic       fe_now;
    logic [2:0] last_bit;
    logic [7:0] rx_word;
    rx_cfg_t    cfg_in;

    assign rx_s       = sync_q[1];
    assign start_edge = rx_prev_q & ~rx_s;
    assign restart    = (state_q == IDLE) && start_edge;
    assign mid_bit    = tick && (smp_q == SMP_MID);

    assign cfg_in = '{bd:    bd_sel_e'(rx_if.bd_sel),
                      prty:  prty_sel_e'(rx_if.prty_sel),
                      stop2: rx_if.stop_sel,
                      dbit8: rx_if.data_bit_sel};

    // 7-bit words land in sh_q[7:1] because bits shift in from the top.
    assign rx_word    = cfg_q.dbit8 ? sh_q : {1'b0, sh_q[7:1]};
    assign last_bit   = cfg_q.dbit8 ? 3'd7 : 3'd6;
    assign parity_en  = (cfg_q.prty == PRTY_ODD) || (cfg_q.prty == PRTY_EVEN);
    assign exp_parity = (^rx_word) ^ (cfg_q.prty == PRTY_ODD);
    assign fe_now     = fe_q | ~rx_s;

    uart_rx_baud_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .bd_sel_i  (cfg_q.bd),
        .tick_o    (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            cfg_q        <= '0;
            smp_q        <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            sh_q         <= '0;
            pe_q         <= 1'b0;
            fe_q         <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_if.data_in_Rx};
            rx_prev_q    <= rx_s;
            data_valid_q <= 1'b0;
            if (tick) begin
                smp_q <= (smp_q == SMP_LAST) ? '0 : smp_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        cfg_q   <= cfg_in;
                        smp_q   <= '0;
                        bit_q   <= '0;
                        stop_q  <= 1'b0;
                        pe_q    <= 1'b0;
                        fe_q    <= 1'b0;
                    end
                end
                START: begin
                    if (mid_bit) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        sh_q <= {rx_s, sh_q[7:1]};
                        if (bit_q == last_bit) begin
                            state_q <= parity_en ? PARITY : STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (mid_bit) begin
                        pe_q    <= (rx_s != exp_parity);
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (mid_bit) begin
                        if (cfg_q.stop2 && !stop_q) begin
                            stop_q <= 1'b1;
                            fe_q   <= fe_now;
                        end else begin
                            data_out_q   <= rx_word;
                            data_valid_q <= 1'b1;
                            parity_err_q <= pe_q;
                            frame_err_q  <= fe_now;
                            // A low line at a failed stop is a break: hold off until it releases.
                            if (fe_now && !rx_s) begin
                                state_q <= BREAK_WAIT;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.data_out   = data_out_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed and randomized frames
module tb_uart_rx;

    // Reduced clock (4 x 16 x 9600) keeps slow-baud frames short; divisors become 32/16/8/4.
    localparam int unsigned TB_CLK_HZ = 614_400;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_rx_if rx();

    uart_rx #(
        .CLK_FREQ_HZ (TB_CLK_HZ),
        .OVERSAMPLE  (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (rx)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    exp_t       exp_q[$];
    exp_t       e_mon;
    logic       line_bits[$];
    logic [1:0] cur_bd;
    logic [1:0] cur_prty;
    logic       cur_stop;
    logic       cur_dbit;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int bit_clks();
        return int'(TB_CLK_HZ / (32'd1200 << cur_bd));
    endfunction

    task automatic set_cfg(input logic [1:0] bd, input logic [1:0] prty, input logic st, input logic db);
        cur_bd = bd; cur_prty = prty; cur_stop = st; cur_dbit = db;
        rx.bd_sel = bd; rx.prty_sel = prty; rx.stop_sel = st; rx.data_bit_sel = db;
    endtask

    // Transmitter view: start, LSB-first data, optional parity, stop bit(s).
    task automatic build_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop);
        logic [7:0] dm;
        logic       p;
        dm = cur_dbit ? d : {1'b0, d[6:0]};
        line_bits.delete();
        line_bits.push_back(1'b0);
        for (int i = 0; i < (cur_dbit ? 8 : 7); i++) line_bits.push_back(dm[i]);
        if (cur_prty == 2'b01 || cur_prty == 2'b10) begin
            p = (cur_prty == 2'b01) ? ($countones(dm) % 2 == 0) : ($countones(dm) % 2 == 1);
            line_bits.push_back(p ^ flip_par);
        end
        line_bits.push_back(!(bad_stop && !cur_stop));
        if (cur_stop) line_bits.push_back(!bad_stop);
    endtask

    // Receiver view: decode whatever sits on the line into word, parity and framing status.
    function automatic exp_t model();
        exp_t e;
        int   k;
        int   ones;
        e = '0;
        for (int i = 0; i < (cur_dbit ? 8 : 7); i++) e.d[i] = line_bits[1 + i];
        k = cur_dbit ? 9 : 8;
        if (cur_prty == 2'b01 || cur_prty == 2'b10) begin
            ones = $countones(e.d) + int'(line_bits[k]);
            e.pe = (cur_prty == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
            k++;
        end
        for (int i = 0; i < (cur_stop ? 2 : 1); i++) begin
            if (line_bits[k + i] == 1'b0) e.fe = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input int abort_at, input bit scramble);
        int bc;
        bc = bit_clks();
        for (int i = 0; i < line_bits.size(); i++) begin
            rx.data_in_Rx = line_bits[i];
            if (i == abort_at) begin
                repeat (bc / 2) @(negedge clk);
                return;
            end
            if (scramble && i == 2) begin
                rx.bd_sel       = 2'($urandom);
                rx.prty_sel     = 2'($urandom);
                rx.stop_sel     = 1'($urandom);
                rx.data_bit_sel = 1'($urandom);
            end
            repeat (bc) @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit flip_par, input bit bad_stop, input bit scramble);
        build_frame(d, flip_par, bad_stop);
        exp_q.push_back(model());
        drive(-1, scramble);
    endtask

    task automatic idle(input int nbits);
        rx.data_in_Rx = 1'b1;
        repeat (nbits * bit_clks()) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst && prev_valid) check("valid_one_clk", 32'(rx.data_valid), 32'd0);
        if (rst && rx.data_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: data_out=%0h with no frame pending at %0t", rx.data_out, $time);
            end else begin
                e_mon = exp_q.pop_front();
                check("frame_word_pe_fe", 32'({rx.data_out, rx.parity_err, rx.frame_err}), 32'(e_mon));
            end
        end
        prev_valid = rst && rx.data_valid;
    end

    initial begin
        rx.data_in_Rx = 1'b1;
        set_cfg(2'b00, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data_out", 32'(rx.data_out), 32'd0);
        check("rst_data_valid", 32'(rx.data_valid), 32'd0);
        check("rst_parity_err", 32'(rx.parity_err), 32'd0);
        check("rst_frame_err", 32'(rx.frame_err), 32'd0);
        check("rst_busy", 32'(rx.busy), 32'd0);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        send(8'h2D, 1'b0, 1'b0, 1'b0);
        idle(2);

        set_cfg(2'b01, 2'b01, 1'b1, 1'b1);
        send(8'h2D, 1'b0, 1'b0, 1'b0);
        send(8'h2D, 1'b1, 1'b0, 1'b0);
        idle(2);

        set_cfg(2'b10, 2'b10, 1'b1, 1'b1);
        send(8'hA5, 1'b0, 1'b1, 1'b0);
        idle(2);

        set_cfg(2'b11, 2'b00, 1'b0, 1'b1);
        rx.data_in_Rx = 1'b0;
        repeat (16) @(negedge clk);
        check("false_start_busy_hi", 32'(rx.busy), 32'd1);
        rx.data_in_Rx = 1'b1;
        repeat (20) @(negedge clk);
        check("false_start_busy_lo", 32'(rx.busy), 32'd0);
        idle(2);
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(1);

        build_frame(8'h81, 1'b0, 1'b0);
        drive(4, 1'b0);
        rx.data_in_Rx = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data_out", 32'(rx.data_out), 32'd0);
        check("midrst_busy", 32'(rx.busy), 32'd0);
        check("midrst_flags", 32'({rx.data_valid, rx.parity_err, rx.frame_err}), 32'd0);
        rst = 1'b1;
        idle(12);
        send(8'h81, 1'b0, 1'b0, 1'b0);
        idle(1);

        set_cfg(2'b00, 2'b00, 1'b0, 1'b1);
        line_bits.delete();
        repeat (20) line_bits.push_back(1'b0);
        exp_q.push_back(model());
        drive(-1, 1'b0);
        check("break_busy_held", 32'(rx.busy), 32'd1);
        rx.data_in_Rx = 1'b1;
        repeat (8) @(negedge clk);
        check("break_busy_release", 32'(rx.busy), 32'd0);
        idle(1);
        send(8'h55, 1'b0, 1'b0, 1'b0);
        idle(1);

        for (int n = 0; n < 16; n++) begin
            logic bad;
            bad = ($urandom_range(0, 4) == 0);
            set_cfg(2'(2 + $urandom_range(0, 1)), 2'($urandom), 1'($urandom), 1'($urandom));
            send(8'($urandom), $urandom_range(0, 3) == 0, bad, 1'b1);
            if (bad) idle(1);
        end
        idle(1);

        repeat (10) @(negedge clk);
        check("all_frames_delivered", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
